// File: rtl/audio_dac_multi.sv
// Multi-channel 1-bit audio DAC: per-channel PWM or first-order sigma-delta modulation,
// fed through a one-deep pending buffer with frame-aligned updates and a sticky underrun flag.
module audio_dac_multi #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned WIDTH     = 9,
  parameter int unsigned MODE      = 0,
  parameter bit          SIGNED_IN = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] sample_in,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  input  logic [CHANNELS-1:0]       mute,
  input  logic                      underrun_clr,
  output logic [CHANNELS-1:0]       out,
  output logic                      frame_start,
  output logic                      underrun
);

  localparam logic [WIDTH-1:0] Mid      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SignFlip = SIGNED_IN ? Mid : '0;

  typedef logic [CHANNELS-1:0][WIDTH-1:0] chan_vec_t;

  logic [WIDTH-1:0]       cnt_q, cnt_d;
  chan_vec_t              pend_q, pend_d;
  logic                   pend_full_q, pend_full_d;
  chan_vec_t              active_q, active_d;
  chan_vec_t              acc_q, acc_d;
  logic [CHANNELS-1:0]    out_q, out_d;
  logic                   fs_q;
  logic                   underrun_q, underrun_d;

  chan_vec_t              conv;
  chan_vec_t              eff;
  logic [CHANNELS-1:0][WIDTH:0] sum;
  logic                   boundary;
  logic                   accept;
  logic                   ur_event;

  assign sample_ready = !pend_full_q && !rst;
  assign boundary     = (cnt_q == '1);
  assign accept       = sample_valid && sample_ready;

  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    active_d    = active_q;
    ur_event    = 1'b0;

    for (int n = 0; n < CHANNELS; n++) begin
      conv[n] = sample_in[n*WIDTH +: WIDTH] ^ SignFlip;
    end

    if (boundary) begin
      if (pend_full_q) begin
        active_d    = pend_q;
        pend_full_d = 1'b0;
      end else if (accept) begin
        // Bypass: a sample landing exactly on the boundary goes straight to active.
        active_d = conv;
      end else begin
        ur_event = 1'b1;
      end
    end else if (accept) begin
      pend_d      = conv;
      pend_full_d = 1'b1;
    end

    // A new underrun in the same cycle as a clear leaves the flag set.
    underrun_d = ur_event | (underrun_q & ~underrun_clr);
  end

  always_comb begin
    eff   = '0;
    sum   = '0;
    acc_d = '0;
    out_d = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      eff[n] = mute[n] ? Mid : active_q[n];
      sum[n] = {1'b0, acc_q[n]} + {1'b0, eff[n]};
      if (MODE == 0) begin
        out_d[n] = (cnt_q < eff[n]);
      end else if (mute[n]) begin
        // Accumulator parked at zero; emit the 50% midscale density directly.
        acc_d[n] = '0;
        out_d[n] = cnt_q[0];
      end else begin
        acc_d[n] = sum[n][WIDTH-1:0];
        out_d[n] = sum[n][WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      active_q    <= {CHANNELS{Mid}};
      acc_q       <= '0;
      out_q       <= '0;
      fs_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      active_q    <= active_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      fs_q        <= boundary;
      underrun_q  <= underrun_d;
    end
  end

  assign out         = out_q;
  assign frame_start = fs_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_audio_dac_multi.sv
// Directed bench for audio_dac_multi: PWM, signed-input and sigma-delta instances share clock
// and reset; per-frame high-cycle counts are compared with hand-computed values.
module tb_audio_dac_multi;

  localparam int unsigned Ch = 2;
  localparam int unsigned W  = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [Ch*W-1:0]   sample;
  logic              valid;
  logic [1:0]        tgt;
  logic [Ch-1:0]     mute_p, mute_d;
  logic              clr;

  logic              rdy_p, rdy_s, rdy_d;
  logic [Ch-1:0]     out_p, out_s, out_d;
  logic              fs_p, fs_s, fs_d;
  logic              ur_p, ur_s, ur_d;

  logic              rdy_sel, fs_sel, ur_sel;
  logic [Ch-1:0]     out_sel;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audio_dac_multi #(.CHANNELS(Ch), .WIDTH(W), .MODE(0), .SIGNED_IN(1'b0)) u_pwm (
    .clk(clk), .rst(rst), .sample_in(sample), .sample_valid(valid && tgt == 2'd0),
    .sample_ready(rdy_p), .mute(mute_p), .underrun_clr(clr), .out(out_p),
    .frame_start(fs_p), .underrun(ur_p)
  );

  audio_dac_multi #(.CHANNELS(Ch), .WIDTH(W), .MODE(0), .SIGNED_IN(1'b1)) u_sgn (
    .clk(clk), .rst(rst), .sample_in(sample), .sample_valid(valid && tgt == 2'd1),
    .sample_ready(rdy_s), .mute(2'b00), .underrun_clr(clr), .out(out_s),
    .frame_start(fs_s), .underrun(ur_s)
  );

  audio_dac_multi #(.CHANNELS(Ch), .WIDTH(W), .MODE(1), .SIGNED_IN(1'b0)) u_sd (
    .clk(clk), .rst(rst), .sample_in(sample), .sample_valid(valid && tgt == 2'd2),
    .sample_ready(rdy_d), .mute(mute_d), .underrun_clr(clr), .out(out_d),
    .frame_start(fs_d), .underrun(ur_d)
  );

  assign rdy_sel = (tgt == 2'd0) ? rdy_p : (tgt == 2'd1) ? rdy_s : rdy_d;
  assign fs_sel  = (tgt == 2'd0) ? fs_p  : (tgt == 2'd1) ? fs_s  : fs_d;
  assign ur_sel  = (tgt == 2'd0) ? ur_p  : (tgt == 2'd1) ? ur_s  : ur_d;
  assign out_sel = (tgt == 2'd0) ? out_p : (tgt == 2'd1) ? out_s : out_d;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a sample and hold it until the selected DUT takes it.
  task automatic offer(input logic [W-1:0] c1, input logic [W-1:0] c0, input bit chk_fs,
                       input string tag);
    int waited = 0;
    sample = {c1, c0};
    valid  = 1'b1;
    #1;
    while (!rdy_sel && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, "_rdy"}, 32'(rdy_sel), 1);
    if (chk_fs) check_eq({tag, "_fs"}, 32'(fs_sel), 1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic wait_fs();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!fs_sel && k < 1000);
    check_eq("align_fs", 32'(fs_sel), 1);
  endtask

  // Count one 512-cycle window; also flags ch0 ones not spaced exactly 4 apart.
  task automatic count_frame(output int hi0, output int hi1, output int nfs, output int bad);
    int last = -1;
    hi0 = 0; hi1 = 0; nfs = 0; bad = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      if (out_sel[1]) hi1++;
      if (fs_sel) nfs++;
      if (out_sel[0]) begin
        hi0++;
        if (last >= 0 && i - last != 4) bad++;
        last = i;
      end
    end
  endtask

  task automatic frame_check(input string tag, input int e0, input int e1);
    int h0, h1, nfs, bad;
    count_frame(h0, h1, nfs, bad);
    check_eq({tag, "_ch0"}, h0, e0);
    check_eq({tag, "_ch1"}, h1, e1);
    check_eq({tag, "_nfs"}, nfs, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, nfs, bad;
    rst = 1'b1; valid = 1'b0; tgt = 2'd0; sample = '0;
    mute_p = '0; mute_d = '0; clr = 1'b0;

    // Reset: outputs quiet, ready low; a handshake during reset is discarded.
    @(negedge clk);
    check_eq("rst_rdy", 32'(rdy_p), 0);
    check_eq("rst_out", 32'(out_p), 0);
    check_eq("rst_fs", 32'(fs_p), 0);
    check_eq("rst_ur", 32'(ur_p), 0);
    sample = {9'd511, 9'd0};
    valid  = 1'b1;
    skip(2);
    rst   = 1'b0;
    valid = 1'b0;
    #1;
    check_eq("post_rst_rdy", 32'(rdy_p), 1);
    frame_check("rst_mid", 256, 256);

    // First boundary had no sample: underrun, then clear it.
    check_eq("ur_first", 32'(ur_p), 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_eq("ur_clr1", 32'(ur_p), 0);
    skip(9);

    // PWM duty plus back-to-back handshake: second sample waits for the boundary.
    offer(9'd511, 9'd0, 1'b0, "pwm_a");
    #1;
    check_eq("rdy_drop", 32'(rdy_p), 0);
    fork
      offer(9'd300, 9'd100, 1'b1, "pwm_b_hold");
      begin
        wait_fs();
        frame_check("pwm_f1", 0, 511);
      end
    join
    check_eq("no_ur_f1", 32'(ur_p), 0);
    frame_check("pwm_f2", 100, 300);
    check_eq("ur_set", 32'(ur_p), 1);
    frame_check("pwm_held", 100, 300);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_eq("ur_clr2", 32'(ur_p), 0);

    // Sample offered exactly on the boundary with pending empty.
    skip(510);
    sample = {9'd50, 9'd20};
    valid  = 1'b1;
    #1;
    check_eq("bnd_rdy", 32'(rdy_p), 1);
    @(negedge clk);
    valid = 1'b0;
    #1;
    check_eq("bnd_fs", 32'(fs_p), 1);
    check_eq("bnd_no_ur", 32'(ur_p), 0);
    check_eq("bnd_not_pending", 32'(rdy_p), 1);
    frame_check("bnd_apply", 20, 50);

    // Mute ch1 mid-frame while it carries 511.
    offer(9'd511, 9'd200, 1'b0, "mute_load");
    skip(511);
    skip(100);
    mute_p = 2'b10;
    skip(201);
    check_eq("mute_mid", 32'(out_p[1]), 0);
    check_eq("mute_ch0", 32'(out_p[0]), 0);
    skip(211);
    frame_check("mute_frame", 200, 256);
    mute_p = 2'b00;

    // Signed conversion: -256 -> 0, 0 -> 256, +255 -> 511.
    tgt = 2'd1;
    fork
      begin
        offer(9'h000, 9'h100, 1'b0, "sgn_a");
        offer(9'h100, 9'h0ff, 1'b0, "sgn_b");
      end
      begin
        wait_fs();
        frame_check("sgn_a", 0, 256);
      end
    join
    frame_check("sgn_b", 511, 0);

    // Sigma-delta: 128 -> one high in every four, 0 -> constant low.
    tgt = 2'd2;
    fork
      begin
        offer(9'd0, 9'd128, 1'b0, "sd_a");
        offer(9'd100, 9'd0, 1'b0, "sd_b");
      end
      begin
        wait_fs();
        count_frame(h0, h1, nfs, bad);
        check_eq("sd_128_cnt", h0, 128);
        check_eq("sd_128_gap", bad, 0);
        check_eq("sd_zero", h1, 0);
        check_eq("sd_a_nfs", nfs, 1);
      end
    join
    frame_check("sd_b", 0, 100);

    // Mute in sigma-delta: accumulator parked, output at midscale density.
    skip(3);
    mute_d = 2'b10;
    @(negedge clk);
    check_eq("sd_mute_acc", 32'(u_sd.acc_q[1]), 0);
    skip(508);
    frame_check("sd_mute", 0, 256);
    check_eq("sd_mute_acc2", 32'(u_sd.acc_q[1]), 0);
    mute_d = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
